led_sched: RTL

LED_SCHED -- requirements
Module: led_sched

---
 rtl/led_sched.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/led_sched.sv
// LED event scheduler: round-robin accepts channel codes from four requesters,
// queues them in a 4-entry FIFO and shows each on an active-low LED bank for a timed hold plus gap.
module led_sched #(
  parameter int unsigned HOLD_US = 300000,
  parameter int unsigned GAP_US  = 50000
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        pluse_us,
  input  logic [3:0]  req,
  input  logic [15:0] req_ch,
  input  logic        clr,
  output logic [3:0]  ack,
  output logic [7:0]  led_ch_n,
  output logic        busy,
  output logic [2:0]  fifo_cnt,
  output logic        err_code
);

  localparam logic [19:0] HOLD_LAST = 20'(HOLD_US - 1);
  localparam logic [19:0] GAP_LAST  = 20'((GAP_US == 0) ? 0 : GAP_US - 1);
  localparam bit          HAS_GAP   = (GAP_US != 0);

  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP} state_t;

  state_t      state, state_nxt;
  logic [19:0] tick_cnt, tick_cnt_nxt;
  logic [7:0]  led_nxt;
  logic        pop;

  logic [3:0]  fifo_mem [4];
  logic [1:0]  wr_ptr, rd_ptr, rr_ptr;

  logic [3:0]  cand;
  logic        grant;
  logic [1:0]  grant_idx;
  logic [3:0]  grant_code;
  logic        code_ok;
  logic        push;

  // Requesters already acked this cycle are masked so a held req is not granted twice.
  always_comb begin
    cand      = req & ~ack;
    grant     = 1'b0;
    grant_idx = rr_ptr;
    for (int unsigned k = 0; k < 4; k++) begin
      if (!grant && cand[rr_ptr + 2'(k)]) begin
        grant     = 1'b1;
        grant_idx = rr_ptr + 2'(k);
      end
    end
    if (clr || fifo_cnt[2]) grant = 1'b0;
    grant_code = req_ch[{grant_idx, 2'b00} +: 4];
    code_ok    = (grant_code != 4'd0) && (grant_code <= 4'd8);
    push       = grant && code_ok;
  end

  always_comb begin
    state_nxt    = state;
    tick_cnt_nxt = tick_cnt;
    led_nxt      = led_ch_n;
    pop          = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (fifo_cnt != 3'd0) begin
          pop          = 1'b1;
          state_nxt    = S_SHOW;
          tick_cnt_nxt = '0;
          led_nxt      = ~(8'd1 << 3'(fifo_mem[rd_ptr] - 4'd1));
        end
      end
      S_SHOW: begin
        if (pluse_us) begin
          if (tick_cnt == HOLD_LAST) begin
            tick_cnt_nxt = '0;
            led_nxt      = '1;
            state_nxt    = HAS_GAP ? S_GAP : S_IDLE;
          end else begin
            tick_cnt_nxt = tick_cnt + 20'd1;
          end
        end
      end
      S_GAP: begin
        if (pluse_us) begin
          if (tick_cnt == GAP_LAST) begin
            tick_cnt_nxt = '0;
            state_nxt    = S_IDLE;
          end else begin
            tick_cnt_nxt = tick_cnt + 20'd1;
          end
        end
      end
      default: begin
        state_nxt    = S_IDLE;
        tick_cnt_nxt = '0;
        led_nxt      = '1;
      end
    endcase
    if (clr) begin
      state_nxt    = S_IDLE;
      tick_cnt_nxt = '0;
      led_nxt      = '1;
      pop          = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      led_ch_n <= '1;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_cnt_nxt;
      led_ch_n <= led_nxt;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) fifo_mem[wr_ptr] <= grant_code;
  end

  // The arbiter pointer deliberately survives clr; only reset rewinds it.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      ack      <= '0;
      rr_ptr   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      err_code <= 1'b0;
    end else begin
      ack <= grant ? (4'b0001 << grant_idx) : 4'b0000;
      if (grant) rr_ptr <= grant_idx + 2'd1;
      if (clr) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fifo_cnt <= '0;
        err_code <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 2'd1;
        if (pop) rd_ptr <= rd_ptr + 2'd1;
        if (grant && !code_ok) err_code <= 1'b1;
        fifo_cnt <= fifo_cnt + {2'b00, push} - {2'b00, pop};
      end
    end
  end

  assign busy = (state != S_IDLE) || (fifo_cnt != 3'd0);

endmodule
